// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryption controller: one cipher round per clock, on-the-fly key expansion,
// valid/ready handshakes on the plaintext input and the ciphertext output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a plaintext/key pair, in_ready high
// S_ROUND | running rounds 1..NR, round_cnt holds the round being computed
// S_DONE  | ciphertext presented on ct_out, waiting for out_ready
module aes128_enc_ctrl #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out
);

    if (NR != 10) begin : g_nr_check
        $error("aes128_enc_ctrl: only NR=10 (AES-128) is supported");
    end

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [127:0]        state_reg, state_d;
    logic [127:0]        key_reg, key_d;
    logic [ROUND_W-1:0]  round_cnt, round_d;
    logic [127:0]        ct_d;
    logic                out_valid_d;

    logic [127:0]        rk;
    logic [127:0]        dp_state_in;
    logic [127:0]        dp_key_in;
    logic [ROUND_W-1:0]  dp_round;
    logic                dp_last;
    logic [127:0]        dp_state_out;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] r);
        logic [7:0] rc;
        case (int'(r))
            1:       rc = 8'h01;
            2:       rc = 8'h02;
            3:       rc = 8'h04;
            4:       rc = 8'h08;
            5:       rc = 8'h10;
            6:       rc = 8'h20;
            7:       rc = 8'h40;
            8:       rc = 8'h80;
            9:       rc = 8'h1b;
            10:      rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i of the block is row i%4, column i/4; byte 0 sits in the top bits.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            b[i] = sbox(s[127 - 8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                t[rr + 4*c] = b[rr + 4*((c + rr) % 4)];
            end
        end
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c + 1];
                a2 = t[4*c + 2];
                a3 = t[4*c + 3];
                t[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = t[i];
        end
        return r ^ k;
    endfunction

    // Single-round datapath: its inputs are only meaningful while in S_ROUND.
    always_comb begin
        rk           = key_expand(key_reg, rcon(round_cnt));
        dp_state_in  = state_reg;
        dp_key_in    = rk;
        dp_round     = round_cnt;
        dp_last      = (dp_round == ROUND_W'(NR));
        dp_state_out = aes_round(dp_state_in, dp_key_in, dp_last);
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_reg;
        key_d       = key_reg;
        round_d     = round_cnt;
        ct_d        = ct_out;
        out_valid_d = out_valid;
        in_ready    = 1'b0;
        unique case (fsm_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = pt_in ^ key_in;
                    key_d   = key_in;
                    round_d = ROUND_W'(1);
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = dp_state_out;
                key_d   = rk;
                round_d = round_cnt + ROUND_W'(1);
                if (dp_last) begin
                    ct_d        = dp_state_out;
                    out_valid_d = 1'b1;
                    round_d     = '0;
                    fsm_d       = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= S_IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            round_cnt <= '0;
            ct_out    <= '0;
            out_valid <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            state_reg <= state_d;
            key_reg   <= key_d;
            round_cnt <= round_d;
            ct_out    <= ct_d;
            out_valid <= out_valid_d;
        end
    end

endmodule
